// File: rtl/risc16_pkg.sv
// Shared types and constants for the risc16 fetch path.
package risc16_pkg;

  localparam int WORD_W = 16;
  localparam logic [WORD_W-1:0] RESET_PC = 16'h0000;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_checker.sv
// Protocol checks for the fetch stage; simulation only, no effect on logic.
module instr_fetch_checker #(
  parameter int DEPTH = 2
) (
  input logic                       clk,
  input logic                       rst_n,
  input logic                       imem_rvalid,
  input logic [$clog2(DEPTH+1)-1:0] outstanding,
  input logic [$clog2(DEPTH+1)-1:0] drop_cnt
);

  localparam int CW = $clog2(DEPTH + 1);

  a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (!rst_n)
    !(imem_rvalid && (outstanding == CW'(0))));

  a_drop_bounded: assert property (@(posedge clk) disable iff (!rst_n)
    drop_cnt <= CW'(DEPTH));

endmodule

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered storage; simultaneous push and pop are legal at any fill level.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             din,
  input  logic                         pop,
  input  logic                         clear,
  output logic [WIDTH-1:0]             dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_push_s;
  logic             do_pop_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == LAST) begin
      ptr_inc = PW'(0);
    end else begin
      ptr_inc = p + PW'(1);
    end
  endfunction

  // pop is ignored when empty; a pop makes room for a push in the same cycle
  always_comb begin
    do_pop_s  = pop && (count_r != CW'(0));
    do_push_s = push && ((count_r != CW'(DEPTH)) || do_pop_s);
  end

  // storage, pointers and fill count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= PW'(0);
      rd_ptr_r <= PW'(0);
      count_r  <= CW'(0);
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= RESET_VAL;
      end
    end else if (clear) begin
      wr_ptr_r <= PW'(0);
      rd_ptr_r <= PW'(0);
      count_r  <= CW'(0);
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= ptr_inc(wr_ptr_r);
      end
      if (do_pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      count_r <= count_r + CW'(do_push_s) - CW'(do_pop_s);
    end
  end

  assign dout  = mem_r[rd_ptr_r];
  assign full  = (count_r == CW'(DEPTH));
  assign empty = (count_r == CW'(0));
  assign count = count_r;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: credit-limited instruction-memory reads, in-order response queue to decode,
// stale-response dropping after a redirect.
module instr_fetch
  import risc16_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] pc_addr,
  input  logic              flush,
  output logic              pc_advance,
  output logic              imem_req,
  output logic [WORD_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [WORD_W-1:0] imem_rdata,
  output logic              if_valid,
  output logic [WORD_W-1:0] if_instr,
  output logic [WORD_W-1:0] if_pc,
  input  logic              id_ready
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] CREDITS = (CW + 1)'(DEPTH);
  localparam fetch_entry_t Q_RESET = '{pc: RESET_PC, instr: 16'h0000};

  logic              active_r;
  logic [CW-1:0]     outstanding_r;
  logic [CW-1:0]     drop_cnt_r;
  logic [CW-1:0]     q_count_s;
  logic [CW-1:0]     af_count_s;
  logic              accept_s;
  logic              resp_s;
  logic              keep_s;
  logic              pop_s;
  logic              af_empty_s;
  logic              af_full_s;
  logic              q_empty_s;
  logic              q_full_s;
  logic [WORD_W-1:0] af_head_s;
  fetch_entry_t      q_din_s;
  fetch_entry_t      q_head_s;
  logic              unused_s;

  // credit uses registered fill levels only, so a pop frees a slot from the next cycle
  always_comb begin
    imem_req   = active_r && !flush &&
                 (({1'b0, q_count_s} + {1'b0, outstanding_r}) < CREDITS);
    imem_addr  = pc_addr;
    accept_s   = imem_req && imem_gnt;
    pc_advance = accept_s;
    resp_s     = imem_rvalid && !af_empty_s;
    keep_s     = resp_s && (drop_cnt_r == CW'(0)) && !flush;
    pop_s      = !q_empty_s && id_ready;
    q_din_s.pc    = af_head_s;
    q_din_s.instr = imem_rdata;
    if_valid   = !q_empty_s;
    if_pc      = q_head_s.pc;
    if_instr   = q_head_s.instr;
  end

  // in-flight accounting; a redirect marks every remaining in-flight read as stale
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_r      <= 1'b0;
      outstanding_r <= CW'(0);
      drop_cnt_r    <= CW'(0);
    end else begin
      active_r      <= 1'b1;
      outstanding_r <= outstanding_r + CW'(accept_s) - CW'(resp_s);
      if (flush) begin
        drop_cnt_r <= outstanding_r - CW'(resp_s);
      end else if (resp_s && (drop_cnt_r != CW'(0))) begin
        drop_cnt_r <= drop_cnt_r - CW'(1);
      end else begin
        drop_cnt_r <= drop_cnt_r;
      end
    end
  end

  sync_fifo #(
    .WIDTH     (WORD_W),
    .DEPTH     (DEPTH),
    .RESET_VAL ({WORD_W{1'b0}})
  ) u_addr_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept_s),
    .din   (pc_addr),
    .pop   (resp_s),
    .clear (1'b0),
    .dout  (af_head_s),
    .full  (af_full_s),
    .empty (af_empty_s),
    .count (af_count_s)
  );

  sync_fifo #(
    .WIDTH     ($bits(fetch_entry_t)),
    .DEPTH     (DEPTH),
    .RESET_VAL (Q_RESET)
  ) u_instr_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (keep_s),
    .din   (q_din_s),
    .pop   (pop_s),
    .clear (flush),
    .dout  (q_head_s),
    .full  (q_full_s),
    .empty (q_empty_s),
    .count (q_count_s)
  );

  instr_fetch_checker #(.DEPTH(DEPTH)) u_checker (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_rvalid (imem_rvalid),
    .outstanding (outstanding_r),
    .drop_cnt    (drop_cnt_r)
  );

  assign unused_s = &{1'b0, af_full_s, q_full_s, af_count_s};

endmodule

// File: tb/tb_instr_fetch.sv
// Directed and randomized bench for instr_fetch against a queue-based reference model.
module tb_instr_fetch;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] pc_addr;
  logic        flush;
  logic        pc_advance;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic        id_ready;

  instr_fetch #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .pc_addr(pc_addr), .flush(flush), .pc_advance(pc_advance),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .if_valid(if_valid),
    .if_instr(if_instr), .if_pc(if_pc), .id_ready(id_ready)
  );

  always #5 clk = ~clk;

  // reads the memory has accepted, in order; stale = issued before a redirect
  typedef struct { logic [15:0] addr; int due; bit stale; } pend_t;
  typedef struct { logic [15:0] pc; logic [15:0] instr; } ent_t;
  pend_t       pend[$];
  ent_t        m_q[$];
  logic [15:0] deq_log[$];

  int          total = 0, bad = 0, cyc = 0, n_adv = 0;
  int          gnt_pct, rdy_pct, lat_min, lat_max;
  bit          flush_now = 1'b0, seen = 1'b0;
  logic [15:0] pc = 16'h0000, flush_pc = 16'h0000, first_pc, last_req;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'hC35A;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    bit   rv, acc, pop, exp_req;
    pend_t p;
    ent_t e;
    imem_gnt    = ($urandom_range(99) < gnt_pct);
    id_ready    = ($urandom_range(99) < rdy_pct);
    rv          = (pend.size() > 0) && (pend[0].due <= cyc);
    imem_rvalid = rv;
    imem_rdata  = rv ? mem_word(pend[0].addr) : 16'($urandom);
    pc_addr     = pc;
    flush       = flush_now;
    @(negedge clk);
    exp_req = !flush_now && ((m_q.size() + pend.size()) < DEPTH);
    acc     = exp_req && imem_gnt;
    pop     = (m_q.size() > 0) && id_ready;
    chk("imem_req", imem_req, exp_req);
    chk("pc_advance", pc_advance, acc);
    chk("imem_addr", imem_addr, pc);
    chk("if_valid", if_valid, m_q.size() > 0);
    if (m_q.size() > 0) begin
      chk("if_pc", if_pc, m_q[0].pc);
      chk("if_instr", if_instr, m_q[0].instr);
    end
    if (if_valid && id_ready) deq_log.push_back(if_pc);
    if (if_valid && !seen) begin
      seen     = 1'b1;
      first_pc = if_pc;
    end
    last_req = 16'(imem_req);
    if (pc_advance) n_adv++;
    @(posedge clk);
    if (pop) void'(m_q.pop_front());
    if (rv) begin
      p = pend.pop_front();
      if (!p.stale && !flush_now) begin
        e.pc    = p.addr;
        e.instr = imem_rdata;
        m_q.push_back(e);
      end
    end
    if (flush_now) begin
      m_q.delete();
      foreach (pend[i]) pend[i].stale = 1'b1;
    end
    if (acc) begin
      p.addr  = pc;
      p.due   = cyc + $urandom_range(lat_max, lat_min);
      p.stale = 1'b0;
      pend.push_back(p);
    end
    pc = flush_now ? flush_pc : (acc ? pc + 16'h0001 : pc);
    cyc++;
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_knobs(input int g, input int r, input int lmin, input int lmax);
    gnt_pct = g; rdy_pct = r; lat_min = lmin; lat_max = lmax;
  endtask

  task automatic finish_reset();
    imem_gnt = 1'b0; imem_rvalid = 1'b0; flush = 1'b0; id_ready = 1'b0;
    pend.delete();
    m_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    cyc++;
  endtask

  initial begin
    bit found;
    rst_n = 1'b0; flush = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
    imem_rdata = 16'h0000; id_ready = 1'b0; pc_addr = 16'h0000;
    #1;
    chk("rst_req", imem_req, 16'h0000);
    chk("rst_valid", if_valid, 16'h0000);
    chk("rst_pc", if_pc, 16'h0000);
    chk("rst_instr", if_instr, 16'h0000);
    @(posedge clk); #1;
    finish_reset();

    // steady stream from PC 0
    set_knobs(100, 100, 1, 1);
    pc = 16'h0000;
    deq_log.delete();
    run(12);
    chk("t2_count", deq_log.size() >= 3, 16'h0001);
    if (deq_log.size() >= 3) begin
      chk("t2_pc0", deq_log[0], 16'h0000);
      chk("t2_pc1", deq_log[1], 16'h0001);
      chk("t2_pc2", deq_log[2], 16'h0002);
    end

    // backpressure: drain, then hold id_ready low
    set_knobs(0, 100, 1, 1);
    run(5);
    set_knobs(100, 0, 1, 1);
    n_adv = 0;
    run(8);
    chk("t3_issued", 16'(n_adv), 16'h0002);
    chk("t3_req_held", last_req, 16'h0000);
    set_knobs(100, 100, 1, 1);
    tick();
    chk("t3_pop_cycle_req", last_req, 16'h0000);
    tick();
    chk("t3_resume_req", last_req, 16'h0001);

    // reset mid-run with the queue full
    set_knobs(100, 0, 1, 1);
    run(6);
    chk("t1_full", if_valid, 16'h0001);
    imem_gnt = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("t1_req", imem_req, 16'h0000);
    chk("t1_adv", pc_advance, 16'h0000);
    chk("t1_valid", if_valid, 16'h0000);
    chk("t1_pc", if_pc, 16'h0000);
    chk("t1_instr", if_instr, 16'h0000);
    finish_reset();

    // flush with two reads in flight
    set_knobs(100, 100, 3, 3);
    pc = 16'h0100;
    n_adv = 0;
    run(2);
    chk("t4_inflight", 16'(n_adv), 16'h0002);
    flush_now = 1'b1; flush_pc = 16'h0040; seen = 1'b0;
    tick();
    flush_now = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) tick();
    chk("t4_seen", seen, 16'h0001);
    chk("t4_first_pc", first_pc, 16'h0040);

    // flush coincident with rvalid, then a second flush
    set_knobs(100, 100, 2, 2);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (pend.size() > 0 && pend[0].due <= cyc) found = 1'b1;
      else tick();
    end
    chk("t5_found", found, 16'h0001);
    flush_now = 1'b1; flush_pc = 16'h0200;
    tick();
    flush_pc = 16'h0300; seen = 1'b0;
    tick();
    flush_now = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) tick();
    chk("t5_seen", seen, 16'h0001);
    chk("t5_first_pc", first_pc, 16'h0300);

    // memory stall at the top of the address space
    set_knobs(0, 100, 4, 4);
    run(8);
    pc = 16'hFFFF;
    n_adv = 0;
    run(3);
    chk("t6_hold", 16'(n_adv), 16'h0000);
    set_knobs(100, 100, 4, 4);
    deq_log.delete();
    run(16);
    chk("t6_count", deq_log.size() >= 2, 16'h0001);
    if (deq_log.size() >= 2) begin
      chk("t6_pc0", deq_log[0], 16'hFFFF);
      chk("t6_pc1", deq_log[1], 16'h0000);
    end

    // randomized traffic with occasional redirects
    set_knobs(70, 60, 1, 4);
    for (int i = 0; i < 400; i++) begin
      flush_now = ($urandom_range(19) == 0);
      flush_pc  = 16'($urandom);
      tick();
    end
    flush_now = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
